// File: rtl/regfile_writeback_controller_pkg.sv
// Shared definitions for the register-file writeback controller.
// Holds the architectural register count, the register address width,
// and the writeback request record (destination register plus data).
package regfile_writeback_controller_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN_DEF   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN_DEF-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/regfile_writeback_controller_rr_arbiter.sv
// Round-robin arbiter with one-hot grant.
// Ports:
//   i_Clock  - clock, rising edge
//   i_Reset  - asynchronous active-low reset; forces grant low and pointer to 0
//   i_Valid  - request vector, one bit per requester
//   o_Grant  - one-hot grant, all zero when nothing is valid
// The sink always accepts, so any grant completes a handshake and moves the
// priority pointer to the slot just after the winner.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         i_Clock,
    input  logic         i_Reset,
    input  logic [N-1:0] i_Valid,
    output logic [N-1:0] o_Grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_scan;
    logic [N-1:0]     w_grant;
    logic             w_found;

    // Scan from the pointer upward (wrapping); first valid slot wins.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_scan  = '0;
        for (int i = 0; i < N; i++) begin
            w_scan = PTR_W'((int'(r_ptr) + i) % N);
            if (!w_found && i_Valid[w_scan]) begin
                w_grant[w_scan] = 1'b1;
                w_idx           = w_scan;
                w_found         = 1'b1;
            end
        end
    end

    assign o_Grant = i_Reset ? w_grant : '0;

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_idx == PTR_W'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_writeback_controller.sv
// Register-file writeback controller: scoreboard plus writeback arbitration.
// Ports:
//   i_Clock, i_Reset              - clock and async active-low reset
//   i_IssueValid, i_IssueRD       - issuing instruction and its destination
//   o_IssueReady                  - issue accepted (destination not busy)
//   i_RS1, i_RS2 / o_RS1Busy, o_RS2Busy - source hazard queries
//   i_ReqValid, i_ReqRD, i_ReqD   - per-requester writeback (flattened vectors)
//   o_ReqReady                    - one-hot round-robin grant
//   o_RD, o_WriteEnable, o_D      - register-file write port, one cycle after handshake
module regfile_writeback_controller
    import regfile_writeback_controller_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int N_REQ = 2
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_IssueValid,
    input  logic [REG_ADDR_W-1:0]         i_IssueRD,
    output logic                          o_IssueReady,
    input  logic [REG_ADDR_W-1:0]         i_RS1,
    input  logic [REG_ADDR_W-1:0]         i_RS2,
    output logic                          o_RS1Busy,
    output logic                          o_RS2Busy,
    input  logic [N_REQ-1:0]              i_ReqValid,
    input  logic [N_REQ*REG_ADDR_W-1:0]   i_ReqRD,
    input  logic [N_REQ*XLEN-1:0]         i_ReqD,
    output logic [N_REQ-1:0]              o_ReqReady,
    output logic [REG_ADDR_W-1:0]         o_RD,
    output logic                          o_WriteEnable,
    output logic [XLEN-1:0]               o_D
);

    logic [REG_COUNT-1:1]   r_busy;
    logic                   r_we;
    logic [REG_ADDR_W-1:0]  r_rd;
    logic [XLEN-1:0]        r_d;

    logic [REG_COUNT-1:0]   w_busy;
    logic [REG_COUNT-1:1]   w_set;
    logic [REG_COUNT-1:1]   w_clr;
    logic                   w_issue_ready;
    logic [N_REQ-1:0]       w_grant;
    logic                   w_hs;
    logic [REG_ADDR_W-1:0]  w_sel_rd;
    logic [XLEN-1:0]        w_sel_d;

    // x0 never has a pending write.
    assign w_busy = {r_busy, 1'b0};

    assign w_issue_ready = i_Reset & i_IssueValid & ~w_busy[i_IssueRD];
    assign o_IssueReady  = w_issue_ready;
    assign o_RS1Busy     = w_busy[i_RS1];
    assign o_RS2Busy     = w_busy[i_RS2];

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int b = 1; b < REG_COUNT; b++) begin
            w_set[b] = w_issue_ready && (i_IssueRD == REG_ADDR_W'(b));
            w_clr[b] = r_we && (r_rd == REG_ADDR_W'(b));
        end
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Valid (i_ReqValid),
        .o_Grant (w_grant)
    );

    assign o_ReqReady = w_grant;
    assign w_hs       = |w_grant;

    always_comb begin
        w_sel_rd = '0;
        w_sel_d  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_grant[k]) begin
                w_sel_rd = i_ReqRD[k*REG_ADDR_W +: REG_ADDR_W];
                w_sel_d  = i_ReqD[k*XLEN +: XLEN];
            end
        end
    end

    // Set wins over clear when both hit the same register at one edge:
    // the new producer's write is still outstanding.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    // Output stage: a writeback to x0 completes its handshake but never writes.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_we <= 1'b0;
            r_rd <= '0;
            r_d  <= '0;
        end else begin
            r_we <= w_hs && (w_sel_rd != '0);
            if (w_hs) begin
                r_rd <= w_sel_rd;
                r_d  <= w_sel_d;
            end
        end
    end

    assign o_WriteEnable = r_we;
    assign o_RD          = r_rd;
    assign o_D           = r_d;

endmodule

// File: tb/tb_regfile_writeback_controller.sv
module tb_regfile_writeback_controller;

    localparam int XLEN  = 32;
    localparam int N_REQ = 2;

    logic                  i_Clock;
    logic                  i_Reset;
    logic                  i_IssueValid;
    logic [4:0]            i_IssueRD;
    logic                  o_IssueReady;
    logic [4:0]            i_RS1;
    logic [4:0]            i_RS2;
    logic                  o_RS1Busy;
    logic                  o_RS2Busy;
    logic [N_REQ-1:0]      i_ReqValid;
    logic [N_REQ*5-1:0]    i_ReqRD;
    logic [N_REQ*XLEN-1:0] i_ReqD;
    logic [N_REQ-1:0]      o_ReqReady;
    logic [4:0]            o_RD;
    logic                  o_WriteEnable;
    logic [XLEN-1:0]       o_D;

    int n_checks = 0;
    int n_errors = 0;

    regfile_writeback_controller #(
        .XLEN  (XLEN),
        .N_REQ (N_REQ)
    ) dut (
        .i_Clock       (i_Clock),
        .i_Reset       (i_Reset),
        .i_IssueValid  (i_IssueValid),
        .i_IssueRD     (i_IssueRD),
        .o_IssueReady  (o_IssueReady),
        .i_RS1         (i_RS1),
        .i_RS2         (i_RS2),
        .o_RS1Busy     (o_RS1Busy),
        .o_RS2Busy     (o_RS2Busy),
        .i_ReqValid    (i_ReqValid),
        .i_ReqRD       (i_ReqRD),
        .i_ReqD        (i_ReqD),
        .o_ReqReady    (o_ReqReady),
        .o_RD          (o_RD),
        .o_WriteEnable (o_WriteEnable),
        .o_D           (o_D)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int k, input logic [4:0] rd, input logic [XLEN-1:0] d);
        i_ReqRD[k*5 +: 5]     = rd;
        i_ReqD[k*XLEN +: XLEN] = d;
    endtask

    task automatic clear_inputs();
        i_IssueValid = 1'b0;
        i_IssueRD    = '0;
        i_RS1        = '0;
        i_RS2        = '0;
        i_ReqValid   = '0;
        i_ReqRD      = '0;
        i_ReqD       = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_Reset = 1'b0;
        step();
        step();
        i_Reset = 1'b1;
        settle();
    endtask

    initial begin
        clear_inputs();
        i_Reset = 1'b0;

        // Reset state, with requests pending to confirm they are masked.
        #2;
        i_IssueValid = 1'b1;
        i_IssueRD    = 5'd3;
        i_ReqValid   = 2'b11;
        settle();
        check("rst_we",      o_WriteEnable, 0);
        check("rst_rd",      o_RD, 0);
        check("rst_d",       o_D, 0);
        check("rst_issuerdy", o_IssueReady, 0);
        check("rst_reqrdy",  o_ReqReady, 0);
        step();
        do_reset();

        // Issue 5, hazard, then write 5 via requester 0.
        i_IssueValid = 1'b1;
        i_IssueRD    = 5'd5;
        settle();
        check("iss5_ready", o_IssueReady, 1);
        step();
        i_IssueValid = 1'b0;
        i_RS1        = 5'd5;
        set_req(0, 5'd5, 32'hDEADBEEF);
        i_ReqValid   = 2'b01;
        settle();
        check("rs1_busy5", o_RS1Busy, 1);
        check("grant_req0", o_ReqReady, 2'b01);
        step();
        i_ReqValid = '0;
        settle();
        check("wr5_we", o_WriteEnable, 1);
        check("wr5_rd", o_RD, 5);
        check("wr5_d",  o_D, 32'hDEADBEEF);
        check("busy5_during_commit", o_RS1Busy, 1);
        step();
        check("wr5_we_off", o_WriteEnable, 0);
        check("busy5_cleared", o_RS1Busy, 0);

        // Round-robin with both requesters held valid for four cycles.
        do_reset();
        set_req(0, 5'd10, 32'h0000_00A0);
        set_req(1, 5'd11, 32'h0000_00B1);
        i_ReqValid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            settle();
            check($sformatf("rr_grant%0d", c), o_ReqReady, (c % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("rr_we%0d", c), o_WriteEnable, (c == 0) ? 1'b0 : 1'b1);
            if (c > 0)
                check($sformatf("rr_rd%0d", c), o_RD, (c % 2 == 1) ? 5'd10 : 5'd11);
            step();
        end
        i_ReqValid = '0;
        settle();
        check("rr_last_we", o_WriteEnable, 1);
        check("rr_last_rd", o_RD, 11);
        check("rr_last_d",  o_D, 32'hB1);
        i_RS1 = 5'd10;
        i_RS2 = 5'd11;
        settle();
        check("nonbusy_wr_rs1", o_RS1Busy, 0);
        check("nonbusy_wr_rs2", o_RS2Busy, 0);
        step();
        check("rr_idle_we", o_WriteEnable, 0);

        // WAW stall on 7 until its commit lands (pointer is 0 here).
        i_IssueValid = 1'b1;
        i_IssueRD    = 5'd7;
        settle();
        check("iss7_first", o_IssueReady, 1);
        step();
        set_req(1, 5'd7, 32'h77);
        i_ReqValid = 2'b10;
        settle();
        check("iss7_stall", o_IssueReady, 0);
        check("grant_req1_only", o_ReqReady, 2'b10);
        step();
        i_ReqValid = '0;
        settle();
        check("commit7_we", o_WriteEnable, 1);
        check("commit7_rd", o_RD, 7);
        check("iss7_stall_commit", o_IssueReady, 0);
        step();
        check("iss7_released", o_IssueReady, 1);
        step();
        i_IssueValid = 1'b0;

        // Issue 9 on the same edge that commits 9 (pointer is 0).
        set_req(0, 5'd9, 32'h99);
        i_ReqValid = 2'b01;
        step();
        i_ReqValid   = '0;
        i_IssueValid = 1'b1;
        i_IssueRD    = 5'd9;
        settle();
        check("commit9_we", o_WriteEnable, 1);
        check("iss9_ready", o_IssueReady, 1);
        step();
        i_IssueValid = 1'b0;
        i_RS1 = 5'd9;
        settle();
        check("busy9_set_wins", o_RS1Busy, 1);

        // Issue to x0 is accepted and changes nothing.
        i_IssueValid = 1'b1;
        i_IssueRD    = 5'd0;
        i_RS1        = 5'd0;
        i_RS2        = 5'd7;
        settle();
        check("iss0_ready", o_IssueReady, 1);
        check("rs_x0_busy", o_RS1Busy, 0);
        step();
        i_IssueValid = 1'b0;
        i_RS1 = 5'd0;
        i_RS2 = 5'd9;
        settle();
        check("rs_x0_after", o_RS1Busy, 0);
        check("busy9_kept", o_RS2Busy, 1);

        // Set 12 and clear 7 on one edge (pointer is 1).
        set_req(1, 5'd7, 32'h7007);
        i_ReqValid = 2'b10;
        step();
        i_ReqValid   = '0;
        i_IssueValid = 1'b1;
        i_IssueRD    = 5'd12;
        settle();
        check("commit7b_rd", o_RD, 7);
        check("iss12_ready", o_IssueReady, 1);
        step();
        i_IssueValid = 1'b0;
        i_RS1 = 5'd7;
        i_RS2 = 5'd12;
        settle();
        check("busy7_cleared", o_RS1Busy, 0);
        check("busy12_set", o_RS2Busy, 1);

        // Writeback to x0 completes but does not write; grant rotates (pointer is 0).
        set_req(0, 5'd0, 32'h1234);
        set_req(1, 5'd3, 32'h3333);
        i_ReqValid = 2'b01;
        settle();
        check("x0_grant", o_ReqReady, 2'b01);
        step();
        i_ReqValid = 2'b11;
        settle();
        check("x0_no_we", o_WriteEnable, 0);
        check("x0_rotated", o_ReqReady, 2'b10);
        i_ReqValid = '0;
        step();

        // Reset mid-stream with busy = 0x0000_0F00 and a write pending.
        do_reset();
        for (int r = 8; r < 12; r++) begin
            i_IssueValid = 1'b1;
            i_IssueRD    = 5'(r);
            step();
        end
        i_IssueValid = 1'b0;
        i_RS1 = 5'd8;
        i_RS2 = 5'd11;
        settle();
        check("pre_rst_busy8", o_RS1Busy, 1);
        check("pre_rst_busy11", o_RS2Busy, 1);
        set_req(0, 5'd8, 32'hCAFE_0008);
        i_ReqValid = 2'b01;
        step();
        check("pre_rst_we", o_WriteEnable, 1);
        i_Reset      = 1'b0;
        i_IssueValid = 1'b1;
        i_IssueRD    = 5'd13;
        settle();
        check("mid_rst_we", o_WriteEnable, 0);
        check("mid_rst_rd", o_RD, 0);
        check("mid_rst_d",  o_D, 0);
        check("mid_rst_busy8", o_RS1Busy, 0);
        check("mid_rst_busy11", o_RS2Busy, 0);
        check("mid_rst_reqrdy", o_ReqReady, 0);
        check("mid_rst_issrdy", o_IssueReady, 0);
        i_IssueValid = 1'b0;
        i_ReqValid   = '0;
        step();
        i_Reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("post_rst_we%0d", c), o_WriteEnable, 0);
        end
        check("post_rst_busy8", o_RS1Busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_controller.md
REGFILE_WRITEBACK_CONTROLLER -- requirements
Module: regfile_writeback_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32: write data width.
REQ-002 SHALL have parameter N_REQ, default 2: number of writeback requesters, legal range 2..4.
REQ-003 SHALL have port i_Clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Reset, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port i_IssueValid, input, 1: an instruction issuing with a destination register.
REQ-006 SHALL have port i_IssueRD, input, 5: destination register of the issuing instruction.
REQ-007 SHALL have port o_IssueReady, output, 1: the issue is accepted this cycle.
REQ-008 SHALL have ports i_RS1 and i_RS2, input, 5 each: source registers to hazard-check.
REQ-009 SHALL have ports o_RS1Busy and o_RS2Busy, output, 1 each: the source has a pending write.
REQ-010 SHALL have port i_ReqValid, input, N_REQ: the requester's writeback is valid.
REQ-011 SHALL have port i_ReqRD, input, N_REQ x 5: the requester's destination register.
REQ-012 SHALL have port i_ReqD, input, N_REQ x XLEN: the requester's write data.
REQ-013 SHALL have port o_ReqReady, output, N_REQ: one-hot grant; the handshake completes when valid and ready are both high.
REQ-014 SHALL have ports o_RD (5), o_WriteEnable (1) and o_D (XLEN), outputs: the register-file write port.

Function
REQ-015 Scoreboard SHALL be a 32-bit busy vector; bit 0 SHALL be constant 0.
REQ-016 o_IssueReady SHALL equal i_IssueValid AND NOT busy[i_IssueRD], combinationally; a destination already busy SHALL stall (WAW guard).
REQ-017 An accepted issue with i_IssueRD != 0 SHALL set busy[i_IssueRD] at the next edge; i_IssueRD = 0 SHALL be accepted without changing state.
REQ-018 o_RSxBusy SHALL equal busy[i_RSx], combinationally, with no bypass from this cycle's issue or commit.
REQ-019 Arbitration SHALL be round-robin over the valid requesters, starting at priority pointer ptr; exactly one o_ReqReady bit SHALL be high when any i_ReqValid bit is high, and none otherwise.
REQ-020 After a granted handshake by requester k, ptr SHALL become (k+1) mod N_REQ; with no handshake, ptr SHALL hold.
REQ-021 A handshake SHALL register rd/data into the output stage; o_WriteEnable SHALL go high the next cycle (latency 1) for exactly one cycle per handshake.
REQ-022 A handshake with rd = 0 SHALL complete, but o_WriteEnable SHALL stay 0.
REQ-023 Commit (o_WriteEnable high) SHALL clear busy[o_RD] at the same edge on which the write lands.
REQ-024 A set and a clear of the same register at one edge SHALL leave the bit set; set and clear of different registers SHALL both take effect.
REQ-025 A write to a register that is not busy SHALL still be performed and SHALL leave busy unchanged.
REQ-026 Back-to-back handshakes SHALL produce back-to-back writes with no bubble, giving one write per cycle of throughput.

Reset
REQ-027 While i_Reset is low: busy = 0, ptr = 0, o_WriteEnable = 0, o_RD = 0, o_D = 0, asynchronously.
REQ-028 During reset, o_ReqReady and o_IssueReady SHALL be 0.
REQ-029 A pending output-stage write SHALL be dropped by reset mid-operation.

Structure
REQ-030 A shared package SHALL hold REG_COUNT = 32, REG_ADDR_W = 5, and a writeback-request struct of rd and data.
REQ-031 A sub-module, rr_arbiter (parameterised N, one-hot grant, pointer update on accept), SHALL implement REQ-019 and REQ-020.
REQ-032 The output port SHALL connect directly to registerfile i_RD, i_WriteEnable and i_D.

Verification
REQ-033 Issue rd = 5, then query i_RS1 = 5 -> o_RS1Busy = 1; req0 writes rd = 5, D = 0xDEADBEEF -> o_WriteEnable, o_RD = 5, o_D = 0xDEADBEEF one cycle later; busy[5] = 0 the cycle after that.
REQ-034 req0 and req1 held valid for 4 cycles after reset -> grants 0, 1, 0, 1, with writes following each grant by 1 cycle.
REQ-035 Issue rd = 7 while busy[7] = 1 -> o_IssueReady = 0; commit of 7 arrives -> o_IssueReady = 1 the next cycle.
REQ-036 Issue rd = 9 in the same cycle as a commit of 9 (issue allowed because busy[9] = 0) -> busy[9] = 1 afterwards; issue rd = 0 -> busy unchanged, o_RS1Busy for x0 = 0.
REQ-037 Handshake rd = 0, D = 0x1234 -> o_WriteEnable stays 0 and the grant rotates.
REQ-038 Assert i_Reset low mid-stream with busy = 0x0000_0F00 -> all outputs and busy go to 0 immediately, and no write occurs after release.
